// File: rtl/vecbuf_feeder_pkg.sv
// Shared types for the vector-buffer feeder: sideband tag and FSM state encoding.
package globals;

   typedef logic [7:0] Info;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      PAD       = 2'd2,
      WAIT_SWAP = 2'd3
   } FeederState;

endpackage

// File: rtl/vecbuf_feeder.sv
// Packs upstream words into DEPTH-lane vectors and drives shift/swap enables of a downstream
// double buffer. Optional VECBUF_FEEDER_PAD_EN zero-pads frames that end mid-vector.
`ifndef VBF_DFF
`define VBF_DFF(q, nxt) always_ff @(posedge clk) if (reset) q <= '0; else q <= (nxt)
`endif

module vecbuf_feeder
   import globals::*;
#(
   parameter int  DEPTH = 8,
   parameter int  WIDTH = 8,
   parameter type Info  = globals::Info
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             din_last,
   input  Info              din_info,
   output logic             din_ready,
   input  logic             swap_ready,
   output logic [WIDTH-1:0] d,
   output logic [1:0]       en,
   output Info              qinfo
);

   localparam int            CW   = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   FeederState       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_d;
   logic [1:0]       r_en;
   Info              r_qinfo;
   logic             r_rdy;

   FeederState       w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] w_d_nxt;
   logic [1:0]       w_en_nxt;
   Info              w_qinfo_nxt;
   logic             w_rdy_nxt;
   logic             w_beat;
   logic             w_acc;
   logic             w_pad_last;

   assign w_acc = din_valid & r_rdy;

`ifdef VECBUF_FEEDER_PAD_EN
   assign w_pad_last = din_last;
`else
   logic w_unused_last;
   assign w_unused_last = din_last;
   assign w_pad_last    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_d_nxt     = '0;
      w_en_nxt    = 2'b00;
      w_qinfo_nxt = r_qinfo;
      w_beat      = 1'b0;
      case (r_state)
         IDLE, FILL: begin
            if (w_acc) begin
               w_beat  = 1'b1;
               w_d_nxt = din;
               if (r_state == IDLE) w_qinfo_nxt = din_info;
               w_state_nxt = (w_pad_last && (r_cnt != LAST)) ? PAD : FILL;
            end
         end
         PAD:       w_beat = 1'b1;
         WAIT_SWAP: begin
            if (swap_ready) begin
               w_en_nxt[1] = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default:   w_state_nxt = IDLE;
      endcase
      // Every beat advances the lane; the DEPTH-th beat closes the vector.
      if (w_beat) begin
         w_en_nxt[0] = 1'b1;
         if (r_cnt == LAST) begin
            w_cnt_nxt = '0;
            if (swap_ready) begin
               w_en_nxt[1] = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT_SWAP;
            end
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
      w_rdy_nxt = (w_state_nxt == IDLE) || (w_state_nxt == FILL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   `VBF_DFF(r_d,     w_d_nxt);
   `VBF_DFF(r_en,    w_en_nxt);
   `VBF_DFF(r_qinfo, w_qinfo_nxt);
   `VBF_DFF(r_rdy,   w_rdy_nxt);

   assign d         = r_d;
   assign en        = r_en;
   assign qinfo     = r_qinfo;
   assign din_ready = r_rdy;

endmodule

// File: tb/tb_vecbuf_feeder.sv
// Scoreboard bench for vecbuf_feeder: a vector-level model predicts every output beat
// (cycle, en, d, qinfo); a monitor pops and compares whenever en is non-zero.
module tb_vecbuf_feeder;
   import globals::*;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
`ifdef VECBUF_FEEDER_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] din = '0;
   logic             din_valid = 1'b0;
   logic             din_last = 1'b0;
   Info              din_info = '0;
   logic             din_ready;
   logic             swap_ready = 1'b1;
   logic [WIDTH-1:0] d;
   logic [1:0]       en;
   Info              qinfo;

   vecbuf_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .Info(Info)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
      .din_info(din_info), .din_ready(din_ready), .swap_ready(swap_ready),
      .d(d), .en(en), .qinfo(qinfo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [1:0]       en;
      logic [WIDTH-1:0] d;
      Info              qi;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   rnd_done = 1'b0;

   int   m_cnt = 0;
   Info  m_tag = '0;
   bit   m_pend = 1'b0;
   bit   m_pad = 1'b0;
   bit   m_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // Model: one more word (or pad) lands in the vector at the coming edge.
   task automatic beat(input logic [WIDTH-1:0] w);
      exp_t e;
      e.cyc = cyc + 1; e.en = 2'b01; e.d = w; e.qi = m_tag;
      q.push_back(e);
      m_cnt++;
      if (m_cnt == DEPTH) begin
         m_cnt = 0;
         m_pad = 1'b0;
         if (swap_ready) q[q.size()-1].en = 2'b11;
         else            m_pend = 1'b1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         chk("din_ready", din_ready, m_rdy);
         if (en != 2'b00) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_beat: got en=%b d=%0h expected no beat at cycle %0d", en, d, cyc);
            end else begin
               e = q.pop_front();
               chk("beat_cycle", cyc, e.cyc);
               chk("en", en, e.en);
               chk("d", d, e.d);
               if (e.en[1]) chk("qinfo", qinfo, e.qi);
            end
         end else begin
            chk("d_idle", d, 0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
               n_chk++; n_fail++;
               $display("FAIL missing_beat: got en=00 expected en=%b d=%0h at cycle %0d", q[0].en, q[0].d, q[0].cyc);
               void'(q.pop_front());
            end
         end
         if (reset) begin
            q.delete(); m_cnt = 0; m_pend = 1'b0; m_pad = 1'b0; m_rdy = 1'b0;
         end else begin
            if (m_pad) beat('0);
            else if (m_pend) begin
               if (swap_ready) begin
                  e.cyc = cyc + 1; e.en = 2'b10; e.d = '0; e.qi = m_tag;
                  q.push_back(e);
                  m_pend = 1'b0;
               end
            end else if (din_valid && m_rdy) begin
               if (m_cnt == 0) m_tag = din_info;
               beat(din);
               if (PAD_EN && din_last && m_cnt != 0) m_pad = 1'b1;
            end
            m_rdy = !m_pend && !m_pad;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] w, input bit last, input Info inf);
      int t = 0;
      bit ok = 1'b0;
      din = w; din_last = last; din_info = inf; din_valid = 1'b1;
      while (!ok && t < 300) begin
         @(negedge clk);
         ok = din_ready;
         t++;
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL send_timeout: got din_ready=0 expected 1 within 300 cycles");
      end
      @(posedge clk); #1;
      din_valid = 1'b0; din_last = 1'b0;
   endtask

   task automatic drained(input string nm);
      chk(nm, q.size(), 0);
   endtask

   initial begin
      idle(3);
      chk("rst_en", en, 0);
      chk("rst_d", d, 0);
      chk("rst_qinfo", qinfo, 0);
      chk("rst_rdy", din_ready, 0);
      reset = 1'b0;
      idle(1);
      chk("rdy_after_rst", din_ready, 1);

      // back-to-back full vector with swap available
      swap_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(WIDTH'(i), 1'b0, 8'hA1);
      idle(4);
      drained("drain_full");

      // downstream busy: swap held off for 5 cycles
      swap_ready = 1'b0;
      for (int i = 9; i <= 16; i++) send(WIDTH'(i), 1'b0, 8'hB2);
      idle(4);
      chk("wait_rdy", din_ready, 0);
      swap_ready = 1'b1;
      idle(3);
      chk("rdy_after_swap", din_ready, 1);
      drained("drain_wait");

      // short frame: padded or left waiting depending on build
      send(8'h31, 1'b0, 8'hC3);
      send(8'h32, 1'b0, 8'hC3);
      send(8'h33, 1'b1, 8'hC3);
      idle(10);
      drained("drain_short");
      for (int i = 4; i <= 8; i++) send(WIDTH'(8'h30 + i), 1'b0, 8'hC4);
      idle(4);
      drained("drain_short_tail");

      // reset mid-vector discards the partial vector
      reset = 1'b1; idle(1); reset = 1'b0; idle(1);
      for (int i = 1; i <= 4; i++) send(WIDTH'(8'h40 + i), 1'b0, 8'hD5);
      reset = 1'b1;
      idle(1);
      chk("rst_mid_en", en, 0);
      reset = 1'b0;
      idle(1);
      for (int i = 1; i <= 8; i++) send(WIDTH'(8'h50 + i), 1'b0, 8'hE6);
      idle(4);
      drained("drain_after_rst");

      // randomized traffic with random back-pressure and frame ends
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               swap_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            repeat (120) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send(WIDTH'($urandom), ($urandom_range(0, 7) == 0), Info'($urandom));
            end
            rnd_done = 1'b1;
         end
      join
      swap_ready = 1'b1;
      idle(30);
      drained("drain_random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: got no completion expected finish before 400000");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

endmodule
